// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit frame serializer: FSM state
// encoding, line levels, parity modes and the parity helper.
package uart_pkg;

  // Frame engine states (3-bit encoding)
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } uart_state_e;

  // Parity modes as presented on parity_odd
  typedef enum logic {
    PARITY_EVEN = 1'b0,
    PARITY_ODD  = 1'b1
  } parity_mode_e;

  // Serial line levels
  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;
  localparam logic UART_STOP_LEVEL  = 1'b1;

  // Widest legal data word; the parity helper works on this width and
  // narrower words are zero-extended, which leaves the XOR unchanged.
  localparam int UART_MAX_DATA_WIDTH = 9;

  // Parity bit for a data word: even parity is the XOR-reduction of the
  // word, odd parity is its inverse.
  function automatic logic uart_parity_bit(
    input logic [UART_MAX_DATA_WIDTH-1:0] data,
    input parity_mode_e                   mode
  );
    logic red;
    red = ^data;
    return (mode == PARITY_ODD) ? ~red : red;
  endfunction

endpackage : uart_pkg

// File: rtl/uart_tx_frame_serializer.sv
// UART transmit framer/serializer. Accepts one word over valid/ready and
// emits start bit, DATA_WIDTH data bits, optional parity and one or two stop
// bits, with every bit boundary aligned to baud_tick.
module uart_tx_frame_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  baud_tick,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic                  parity_en,
  input  logic                  parity_odd,
  input  logic                  two_stop,
  output logic                  tx_serial,
  output logic                  tx_busy,
  output logic                  frame_done
);

  import uart_pkg::*;

  // Bit counter only has to reach DATA_WIDTH-1; the last index leaves DATA
  // so the counter never wraps.
  localparam int                IDX_W    = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0]  IDX_ZERO = {IDX_W{1'b0}};

  // Frame state and latched frame configuration
  uart_state_e                  r_state;
  logic [DATA_WIDTH-1:0]        r_data;
  logic [DATA_WIDTH-1:0]        r_shift;
  logic [IDX_W-1:0]             r_bit_idx;
  logic                         r_parity_en;
  parity_mode_e                 r_parity_mode;
  logic                         r_two_stop;
  logic                         r_second_stop;
  logic                         r_tx_serial;
  logic                         r_frame_done;

  // Derived combinational values
  logic [DATA_WIDTH-1:0]          w_ordered;
  logic [UART_MAX_DATA_WIDTH-1:0] w_data_ext;
  logic                           w_parity;
  logic [DATA_WIDTH-1:0]          w_shift_next;

  // Put the incoming word into transmit order so the engine always shifts
  // out bit 0 first, regardless of MSB_FIRST.
  always_comb begin
    w_ordered = {DATA_WIDTH{1'b0}};
    for (int k = 0; k < DATA_WIDTH; k++) begin
      if (MSB_FIRST) begin
        w_ordered[k] = tx_data[DATA_WIDTH-1-k];
      end else begin
        w_ordered[k] = tx_data[k];
      end
    end
  end

  // Parity is taken from the latched word, never from the live input
  assign w_data_ext   = UART_MAX_DATA_WIDTH'(r_data);
  assign w_parity     = uart_parity_bit(w_data_ext, r_parity_mode);
  assign w_shift_next = {1'b0, r_shift[DATA_WIDTH-1:1]};

  // Frame engine: handshake, bit sequencing and registered line/pulse outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_data        <= {DATA_WIDTH{1'b0}};
      r_shift       <= {DATA_WIDTH{1'b0}};
      r_bit_idx     <= IDX_ZERO;
      r_parity_en   <= 1'b0;
      r_parity_mode <= PARITY_EVEN;
      r_two_stop    <= 1'b0;
      r_second_stop <= 1'b0;
      r_tx_serial   <= UART_IDLE_LEVEL;
      r_frame_done  <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_tx_serial <= UART_IDLE_LEVEL;
          // A baud_tick in this same cycle is deliberately ignored: the
          // start bit waits for the next tick seen in ARM.
          if (tx_valid) begin
            r_data        <= tx_data;
            r_shift       <= w_ordered;
            r_bit_idx     <= IDX_ZERO;
            r_parity_en   <= parity_en;
            r_parity_mode <= parity_mode_e'(parity_odd);
            r_two_stop    <= two_stop;
            r_second_stop <= 1'b0;
            r_state       <= ARM;
          end
        end

        ARM: begin
          if (baud_tick) begin
            r_tx_serial <= UART_START_LEVEL;
            r_state     <= START;
          end
        end

        START: begin
          if (baud_tick) begin
            r_tx_serial <= r_shift[0];
            r_shift     <= w_shift_next;
            r_bit_idx   <= IDX_ZERO;
            r_state     <= DATA;
          end
        end

        DATA: begin
          if (baud_tick) begin
            if (r_bit_idx < LAST_IDX) begin
              r_tx_serial <= r_shift[0];
              r_shift     <= w_shift_next;
              r_bit_idx   <= r_bit_idx + IDX_ONE;
            end else if (r_parity_en) begin
              r_tx_serial <= w_parity;
              r_state     <= PARITY;
            end else begin
              r_tx_serial   <= UART_STOP_LEVEL;
              r_second_stop <= 1'b0;
              r_state       <= STOP;
            end
          end
        end

        PARITY: begin
          if (baud_tick) begin
            r_tx_serial   <= UART_STOP_LEVEL;
            r_second_stop <= 1'b0;
            r_state       <= STOP;
          end
        end

        STOP: begin
          if (baud_tick) begin
            r_tx_serial <= UART_STOP_LEVEL;
            if (r_two_stop && !r_second_stop) begin
              r_second_stop <= 1'b1;
            end else begin
              r_frame_done <= 1'b1;
              r_state      <= IDLE;
            end
          end
        end

        default: begin
          r_tx_serial <= UART_IDLE_LEVEL;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  // Status is decoded from the registered state so ready and busy are
  // always exact complements and follow reset asynchronously.
  assign tx_ready   = (r_state == IDLE);
  assign tx_busy    = (r_state != IDLE);
  assign tx_serial  = r_tx_serial;
  assign frame_done = r_frame_done;

endmodule : uart_tx_frame_serializer

// File: tb/tb_uart_tx_frame_serializer.sv
// Self-checking bench for uart_tx_frame_serializer. Two instances share the
// clock and inputs: one LSB-first, one MSB-first. Expected line bits are
// pushed to a queue when a word is offered and popped on every baud_tick.
module tb_uart_tx_frame_serializer;

  localparam int DW       = 8;
  localparam int TICK_DIV = 8;
  localparam int BUDGET   = 4 * TICK_DIV;

  logic          clk = 1'b0;
  logic          reset;
  logic          baud_tick = 1'b0;
  logic [DW-1:0] tx_data = 8'h00;
  logic          tx_valid = 1'b0;
  logic          tx_valid_m = 1'b0;
  logic          parity_en = 1'b0;
  logic          parity_odd = 1'b0;
  logic          two_stop = 1'b0;

  logic tx_ready, tx_serial, tx_busy, frame_done;
  logic tx_ready_m, tx_serial_m, tx_busy_m, frame_done_m;

  logic sel = 1'b0;
  logic w_ser, w_ready, w_busy, w_done;
  logic tick_q = 1'b0;

  int   n_vec = 0;
  int   n_err = 0;
  logic exp_q[$];

  uart_tx_frame_serializer #(.DATA_WIDTH(DW), .MSB_FIRST(1'b0)) dut (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .parity_en(parity_en),
    .parity_odd(parity_odd), .two_stop(two_stop), .tx_serial(tx_serial),
    .tx_busy(tx_busy), .frame_done(frame_done)
  );

  uart_tx_frame_serializer #(.DATA_WIDTH(DW), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .tx_data(tx_data),
    .tx_valid(tx_valid_m), .tx_ready(tx_ready_m), .parity_en(parity_en),
    .parity_odd(parity_odd), .two_stop(two_stop), .tx_serial(tx_serial_m),
    .tx_busy(tx_busy_m), .frame_done(frame_done_m)
  );

  assign w_ser   = sel ? tx_serial_m  : tx_serial;
  assign w_ready = sel ? tx_ready_m   : tx_ready;
  assign w_busy  = sel ? tx_busy_m    : tx_busy;
  assign w_done  = sel ? frame_done_m : frame_done;

  always #5 clk = ~clk;

  // Baud strobe: one clk high every TICK_DIV clocks, changed on negedge
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (cnt == TICK_DIV - 1) begin
        cnt = 0;
        baud_tick = 1'b1;
      end else begin
        cnt = cnt + 1;
        baud_tick = 1'b0;
      end
    end
  end

  // Remember whether the last posedge carried a tick, for negedge sampling
  always @(posedge clk) tick_q <= baud_tick;

  // Hard stop if something hangs
  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // Push n expected line bits, bits[n-1] first on the line
  task automatic push_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(bits[i]);
  endtask

  task automatic wait_tick_edge(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < BUDGET; c++) begin
      @(posedge clk);
      if (baud_tick === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Offer a word just after a tick and wait for the transfer
  task automatic accept_word(input logic [7:0] data, input logic pe, input logic po,
                             input logic ts, input logic msb, input logic hold);
    bit ok;
    bit got;
    sel = msb;
    wait_tick_edge(ok);
    @(negedge clk);
    tx_data = data; parity_en = pe; parity_odd = po; two_stop = ts;
    if (msb) tx_valid_m = 1'b1;
    else     tx_valid   = 1'b1;
    got = 1'b0;
    for (int c = 0; c < BUDGET; c++) begin
      if (w_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_vec++;
    if (!got || !ok) begin
      n_err++;
      $display("FAIL accept_timeout got ready=%b tick=%b, required 1 1", got, ok);
      tx_valid = 1'b0; tx_valid_m = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    if (!hold) begin
      // Scramble inputs: the frame in flight must not notice
      tx_valid = 1'b0; tx_valid_m = 1'b0;
      tx_data = ~data; parity_en = ~pe; parity_odd = ~po; two_stop = ~ts;
    end
    n_vec++;
    if ({w_busy, w_ready, w_ser} !== 3'b101) begin
      n_err++;
      $display("FAIL accept_state busy/ready/line got=%b required=101", {w_busy, w_ready, w_ser});
    end
  endtask

  // Follow one frame of nbits line bits plus the tick that ends it
  task automatic mon_frame(input int nbits);
    logic prev;
    logic exp;
    bit   got;
    prev = 1'b1;
    for (int i = 0; i <= nbits; i++) begin
      got = 1'b0;
      for (int c = 0; c < BUDGET; c++) begin
        @(negedge clk);
        if (tick_q) begin
          got = 1'b1;
          break;
        end
        n_vec++;
        if (w_ser !== prev || w_done !== 1'b0) begin
          n_err++;
          $display("FAIL hold_bit%0d line/done got=%b%b required=%b0", i, w_ser, w_done, prev);
        end
        n_vec++;
        if ((w_ready & w_busy) !== 1'b0) begin
          n_err++;
          $display("FAIL ready_while_busy got ready=%b busy=%b", w_ready, w_busy);
        end
      end
      if (!got) begin
        n_vec++; n_err++;
        $display("FAIL tick_timeout bit %0d got no tick, required one", i);
        return;
      end
      if (i < nbits) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL scoreboard_empty at bit %0d", i);
          return;
        end
        exp = exp_q.pop_front();
        n_vec++;
        if ({w_ser, w_done, w_busy, w_ready} !== {exp, 3'b010}) begin
          n_err++;
          $display("FAIL bit%0d line/done/busy/ready got=%b required=%b",
                   i, {w_ser, w_done, w_busy, w_ready}, {exp, 3'b010});
        end
        prev = exp;
      end else begin
        n_vec++;
        if ({w_ser, w_done, w_busy, w_ready} !== 4'b1101) begin
          n_err++;
          $display("FAIL frame_end line/done/busy/ready got=%b required=1101",
                   {w_ser, w_done, w_busy, w_ready});
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({tx_ready, tx_busy, tx_serial, frame_done} !== 4'b1010) begin
      n_err++;
      $display("FAIL reset_lsb ready/busy/line/done got=%b required=1010",
               {tx_ready, tx_busy, tx_serial, frame_done});
    end
    n_vec++;
    if ({tx_ready_m, tx_busy_m, tx_serial_m, frame_done_m} !== 4'b1010) begin
      n_err++;
      $display("FAIL reset_msb ready/busy/line/done got=%b required=1010",
               {tx_ready_m, tx_busy_m, tx_serial_m, frame_done_m});
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_lsb_basic();
    accept_word(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_bits(16'(10'b0101001011), 10);
    mon_frame(10);
    @(negedge clk);
    n_vec++;
    if ({frame_done, tx_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL done_pulse_width done/ready got=%b required=01", {frame_done, tx_ready});
    end
  endtask

  task automatic test_parity();
    accept_word(8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    push_bits(16'(11'b01110000011), 11);
    mon_frame(11);
    accept_word(8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    push_bits(16'(11'b01110000001), 11);
    mon_frame(11);
  endtask

  task automatic test_two_stop();
    accept_word(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push_bits(16'(11'b00000000011), 11);
    mon_frame(11);
  endtask

  task automatic test_msb_first();
    accept_word(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    push_bits(16'(10'b0100000011), 10);
    mon_frame(10);
    accept_word(8'hC0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    push_bits(16'(10'b0110000001), 10);
    mon_frame(10);
    sel = 1'b0;
  endtask

  task automatic test_back_to_back();
    accept_word(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tx_data = 8'hAA;
    push_bits(16'(10'b0101010101), 10);
    mon_frame(10);
    @(negedge clk);
    n_vec++;
    if ({tx_busy, tx_ready, tx_serial} !== 3'b101) begin
      n_err++;
      $display("FAIL b2b_second_accept busy/ready/line got=%b required=101",
               {tx_busy, tx_ready, tx_serial});
    end
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    push_bits(16'(10'b0010101011), 10);
    mon_frame(10);
  endtask

  task automatic test_tick_on_accept();
    bit ok;
    sel = 1'b0;
    wait_tick_edge(ok);
    repeat (TICK_DIV - 1) @(posedge clk);
    @(negedge clk);
    tx_data = 8'h3C; parity_en = 1'b1; parity_odd = 1'b0; two_stop = 1'b0;
    tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'hFF;
    n_vec++;
    if ({tx_busy, tx_serial} !== 2'b11) begin
      n_err++;
      $display("FAIL tick_on_accept busy/line got=%b required=11", {tx_busy, tx_serial});
    end
    push_bits(16'(11'b00011110001), 11);
    mon_frame(11);
  endtask

  task automatic test_reset_midframe();
    int cnt;
    accept_word(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cnt = 0;
    for (int c = 0; c < 8 * BUDGET; c++) begin
      @(negedge clk);
      if (tick_q) begin
        cnt++;
        if (cnt == 6) break;
      end
    end
    n_vec++;
    if (cnt != 6 || tx_serial !== 1'b0) begin
      n_err++;
      $display("FAIL midframe_bit4 ticks/line got=%0d/%b required=6/0", cnt, tx_serial);
    end
    #2;
    reset = 1'b0;
    #1;
    n_vec++;
    if ({tx_serial, tx_busy, tx_ready, frame_done} !== 4'b1010) begin
      n_err++;
      $display("FAIL async_abort line/busy/ready/done got=%b required=1010",
               {tx_serial, tx_busy, tx_ready, frame_done});
    end
    @(negedge clk);
    reset = 1'b1;
    accept_word(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_bits(16'(10'b0001111001), 10);
    mon_frame(10);
  endtask

  initial begin
    test_reset();
    test_lsb_basic();
    test_parity();
    test_two_stop();
    test_msb_first();
    test_back_to_back();
    test_tick_on_accept();
    test_reset_midframe();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover got=%0d entries, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_uart_tx_frame_serializer

// File: doc/uart_tx_frame_serializer.md
Name: uart_tx_frame_serializer

Overview:
Complete UART transmit framer and serializer. It accepts a parallel word over a valid/ready handshake and emits one frame on the serial line: start bit, DATA_WIDTH data bits, optional parity, then 1 or 2 stop bits. All bit boundaries align to an external baud_tick strobe from the baud generator. It sits between the TX FIFO / host interface and the pad. It replaces the bare index-driven bit-select register with a self-sequencing frame engine.

Parameters:
DATA_WIDTH, 8, data bits per frame (5..9 legal).
MSB_FIRST, 0, 0 = LSB transmitted first (UART standard); 1 = MSB first.

Ports:
clk  input  1  system clock; all state updates on posedge.
reset  input  1  asynchronous, active-low reset.
baud_tick  input  1  one-clk pulse per bit period; ignored in IDLE.
tx_data  input  DATA_WIDTH  word to transmit.
tx_valid  input  1  tx_data is valid.
tx_ready  output  1  block can accept a word; high only in IDLE.
parity_en  input  1  1 = append parity bit; sampled at acceptance.
parity_odd  input  1  1 = odd parity, 0 = even; sampled at acceptance.
two_stop  input  1  1 = two stop bits; sampled at acceptance.
tx_serial  output  1  serial line, registered; idles high.
tx_busy  output  1  high from acceptance until the frame ends.
frame_done  output  1  one-clk pulse on the tick that ends the last stop bit.

Behaviour:
- Reset (asynchronous, active-low):
  - state = IDLE, tx_serial = 1, tx_busy = 0, frame_done = 0.
  - Bit counter and shift register cleared.
  - Reset mid-frame aborts the frame immediately. The line returns high; no partial stop bit is sent.
- Handshake:
  - Transfer occurs on a posedge where tx_valid && tx_ready.
  - tx_ready = (state == IDLE), decoded from registered state.
  - On transfer, the block latches tx_data, parity_en, parity_odd and two_stop, then enters ARM.
  - Input changes after acceptance have no effect on the current frame.
- States (advance only on baud_tick, except IDLE→ARM):
  - IDLE: tx_serial = 1. Go to ARM on transfer.
  - ARM: line still high. On baud_tick, tx_serial <= 0 and go to START.
  - START: on baud_tick, drive the first data bit, clear bit_idx, go to DATA.
  - DATA: on each baud_tick:
    - If bit_idx < DATA_WIDTH-1, increment bit_idx and drive the next bit.
    - Otherwise drive the parity bit and go to PARITY if the parity enable is latched high.
    - Otherwise drive 1 and go to STOP.
  - PARITY: on baud_tick, drive 1 and go to STOP.
  - STOP: on baud_tick:
    - If two_stop is latched and this is the first stop bit, stay in STOP; the line stays 1.
    - Otherwise pulse frame_done and go to IDLE.
- Bit ordering: data bit k is tx_data[k] if MSB_FIRST = 0, else tx_data[DATA_WIDTH-1-k].
- Bit counter width is $clog2(DATA_WIDTH). Wrap-around is never reached; the last index exits DATA.
- Parity bit:
  - Even parity: XOR-reduction of the latched data.
  - Odd parity: the inverse of that XOR.
- Timing:
  - Every frame bit lasts exactly one baud_tick period.
  - The start bit falling edge appears one clk after the first baud_tick following acceptance.
  - Frame length in ticks = 1 + DATA_WIDTH + parity_en + (1 + two_stop).
- Back-to-back frames: tx_ready rises the cycle after frame_done. A word held on tx_valid is accepted then. The line stays high for at least one full tick (the ARM state) between frames.
- tx_busy = (state != IDLE).
- baud_tick coincident with acceptance in IDLE is ignored; the block waits for the next tick.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding localparams: IDLE, ARM, START, DATA, PARITY, STOP (3-bit);
  - UART_IDLE_LEVEL = 1'b1;
  - parity mode constants.
- Single module; no sub-module is warranted. Parity is a reduction expression on the latched word.

Test Plan:
- DATA_WIDTH=8, LSB first, no parity, 1 stop, tx_data=0xA5 → line per tick 0,1,0,1,0,0,1,0,1,1. frame_done pulses once on the 10th tick; tx_ready then returns high.
- 0x07, even parity, 1 stop → data bits 1,1,1,0,0,0,0,0, then parity 1, then stop 1. Repeat with odd parity → parity 0.
- two_stop=1, 0x00 → start, 8 zeros, 2 stop ticks high. Frame is 11 ticks; frame_done only after the 2nd stop tick.
- MSB_FIRST=1, 0x81 → data bits 1,0,0,0,0,0,0,1. 0xC0 → 1,1,0,0,0,0,0,0.
- tx_valid held high with words 0x55 then 0xAA → second word accepted the cycle after frame_done. At least one full high tick between frames; tx_ready is never high while tx_busy is high.
- Assert reset during data bit 4 → tx_serial = 1, tx_busy = 0, tx_ready = 1 asynchronously. A fresh 0x3C after release transmits correctly from its start bit.
